// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the CPU, device and RAM signal groups of the
// RAM arbiter.
//
// Modports
//   slave  : the arbiter side. Requests come in, grants and read returns go
//            out, and the RAM control outputs plus mem_rdata are here too.
//   master : the environment side. This covers the requesters and the RAM.
//
// Signals
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> arbiter
//   cpu_gnt/cpu_rvalid/cpu_rdata      <- arbiter
//   dev_req/dev_we/dev_addr/dev_wdata/dev_lock -> arbiter
//   dev_gnt/dev_rvalid/dev_rdata      <- arbiter
//   mem_en/mem_we/mem_addr/mem_wdata  <- arbiter (RAM port)
//   mem_rdata                         -> arbiter (one-cycle RAM read data)
interface ram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dev_req;
    logic              dev_we;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_wdata;
    logic              dev_lock;
    logic              dev_gnt;
    logic              dev_rvalid;
    logic [DATA_W-1:0] dev_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dev_req, dev_we, dev_addr, dev_wdata, dev_lock,
        output dev_gnt, dev_rvalid, dev_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dev_req, dev_we, dev_addr, dev_wdata, dev_lock,
        input  dev_gnt, dev_rvalid, dev_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the CPU memory
// stage and one device port.
//
// The CPU has fixed priority, with two exceptions. A starvation counter
// forces a device grant after STARVE_MAX denied cycles. A lock mode lets the
// device hold the RAM for up to LOCK_MAX back-to-back grants; after that the
// CPU is given a guaranteed RELEASE slot. Grants are combinational. Read data
// returns one cycle after the grant and is routed to the requester that was
// granted.
//
// Ports
//   clk        : clock (rising edge)
//   reset_low  : asynchronous, active-low reset
//   bus        : ram_arbiter_if.slave, which carries the CPU, device and RAM groups
//   stat_clr, stat_cpu_stall, stat_dev_force : exist only when
//                RAM_ARB_STATS_EN is defined
//
// Optional feature macro: RAM_ARB_STATS_EN. It adds saturating stall and
// forced-grant counters.
module ram_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic        clk,
    input  logic        reset_low,
`ifdef RAM_ARB_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_cpu_stall,
    output logic [15:0] stat_dev_force,
`endif
    ram_arbiter_if.slave bus
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_LOCK    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     state_reg;
    logic [7:0] starve_cnt_reg;
    logic [7:0] lock_cnt_reg;
    logic [7:0] lock_cnt_next;
    logic       cpu_rvalid_reg;
    logic       dev_rvalid_reg;

    logic       arb_mode;
    logic       force_dev;
    logic       cpu_gnt_c;
    logic       dev_gnt_c;

    assign lock_cnt_next = lock_cnt_reg + 8'd1;

    // Grant decision. A LOCK cycle with dev_req or dev_lock low falls back
    // to normal priority arbitration in that same cycle.
    always_comb begin
        arb_mode  = 1'b0;
        force_dev = 1'b0;
        cpu_gnt_c = 1'b0;
        dev_gnt_c = 1'b0;
        case (state_reg)
            ST_LOCK: begin
                if (bus.dev_req && bus.dev_lock) begin
                    dev_gnt_c = 1'b1;
                end else begin
                    arb_mode = 1'b1;
                end
            end
            ST_RELEASE: begin
                cpu_gnt_c = bus.cpu_req;
                dev_gnt_c = bus.dev_req && !bus.cpu_req;
            end
            default: arb_mode = 1'b1;
        endcase
        if (arb_mode) begin
            force_dev = bus.dev_req && (starve_cnt_reg == STARVE_LIM);
            dev_gnt_c = bus.dev_req && (force_dev || !bus.cpu_req);
            cpu_gnt_c = bus.cpu_req && !dev_gnt_c;
        end
        // Grants are combinational, so they have to be masked explicitly to
        // keep every output at 0 while reset is held.
        if (!reset_low) begin
            force_dev = 1'b0;
            cpu_gnt_c = 1'b0;
            dev_gnt_c = 1'b0;
        end
    end

    assign bus.cpu_gnt = cpu_gnt_c;
    assign bus.dev_gnt = dev_gnt_c;

    // RAM port mux. It drives zeros on idle cycles so the address and data
    // buses stay quiet.
    assign bus.mem_en    = cpu_gnt_c | dev_gnt_c;
    assign bus.mem_we    = cpu_gnt_c ? bus.cpu_we    : (dev_gnt_c ? bus.dev_we    : 1'b0);
    assign bus.mem_addr  = cpu_gnt_c ? bus.cpu_addr  : (dev_gnt_c ? bus.dev_addr  : '0);
    assign bus.mem_wdata = cpu_gnt_c ? bus.cpu_wdata : (dev_gnt_c ? bus.dev_wdata : '0);

    // The read-return tag is stored as one bit per requester: granted AND
    // not a write. Writes therefore never produce an rvalid.
    assign bus.cpu_rvalid = cpu_rvalid_reg;
    assign bus.dev_rvalid = dev_rvalid_reg;
    assign bus.cpu_rdata  = cpu_rvalid_reg ? bus.mem_rdata : '0;
    assign bus.dev_rdata  = dev_rvalid_reg ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_reg      <= ST_ARB;
            starve_cnt_reg <= 8'd0;
            lock_cnt_reg   <= 8'd0;
            cpu_rvalid_reg <= 1'b0;
            dev_rvalid_reg <= 1'b0;
        end else begin
            cpu_rvalid_reg <= cpu_gnt_c && !bus.cpu_we;
            dev_rvalid_reg <= dev_gnt_c && !bus.dev_we;

            if (bus.dev_req && !dev_gnt_c) begin
                if (starve_cnt_reg != STARVE_LIM) begin
                    starve_cnt_reg <= starve_cnt_reg + 8'd1;
                end
            end else begin
                starve_cnt_reg <= 8'd0;
            end

            if (arb_mode) begin
                // Lock mode can only be entered from a priority-arbitrated
                // cycle. The first grant counts as lock grant number one.
                if (dev_gnt_c && bus.dev_lock) begin
                    state_reg    <= ST_LOCK;
                    lock_cnt_reg <= 8'd1;
                end else begin
                    state_reg <= ST_ARB;
                end
            end else if (state_reg == ST_LOCK) begin
                lock_cnt_reg <= lock_cnt_next;
                if (lock_cnt_next == LOCK_LIM) begin
                    state_reg <= ST_RELEASE;
                end
            end else begin
                state_reg <= ST_ARB;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stat_cpu_stall_reg;
    logic [15:0] stat_dev_force_reg;

    assign stat_cpu_stall = stat_cpu_stall_reg;
    assign stat_dev_force = stat_dev_force_reg;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            stat_cpu_stall_reg <= 16'd0;
            stat_dev_force_reg <= 16'd0;
        end else if (stat_clr) begin
            stat_cpu_stall_reg <= 16'd0;
            stat_dev_force_reg <= 16'd0;
        end else begin
            if (bus.cpu_req && !cpu_gnt_c && (stat_cpu_stall_reg != 16'hFFFF)) begin
                stat_cpu_stall_reg <= stat_cpu_stall_reg + 16'd1;
            end
            if (force_dev && (stat_dev_force_reg != 16'hFFFF)) begin
                stat_dev_force_reg <= stat_dev_force_reg + 16'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters and no extra ports. Arbitration
    // behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with
// STARVE_MAX=4 and LOCK_MAX=8. A behavioural synchronous RAM with
// one-cycle read latency sits on the mem_* port. Inputs change on the
// falling edge, and all outputs are sampled 1 ns later.
module tb_ram_arbiter;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic clk;
    logic reset_low;
    int   n_checks;
    int   n_fail;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cpu_stall;
    logic [15:0] stat_dev_force;
`endif

    ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .LOCK_MAX(8)
    ) dut (
        .clk(clk),
        .reset_low(reset_low),
`ifdef RAM_ARB_STATS_EN
        .stat_clr(stat_clr),
        .stat_cpu_stall(stat_cpu_stall),
        .stat_dev_force(stat_dev_force),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preset pattern held by every RAM word that has not been written.
    function automatic logic [31:0] pat(input logic [16:0] a);
        return 32'hA500_0000 | {15'd0, a};
    endfunction

    logic [31:0] ram [0:(1<<17)-1];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cpu_req = 1'b0; bus.dev_req = 1'b0; bus.dev_lock = 1'b0;
            bus.cpu_we = 1'b0;  bus.dev_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_low = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'h10; bus.cpu_wdata = 32'h1;
        bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 17'h20; bus.dev_wdata = 32'h2;
        bus.dev_lock = 1'b1;
`ifdef RAM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.dev_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: cpu_gnt=%b dev_gnt=%b required 0 0", bus.cpu_gnt, bus.dev_gnt);
        end
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_mem: en=%b we=%b addr=%h wdata=%h required all 0",
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.dev_rvalid !== 1'b0 || bus.cpu_rdata !== '0 || bus.dev_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rv: cpu_rv=%b dev_rv=%b cpu_rd=%h dev_rd=%h required all 0",
                               bus.cpu_rvalid, bus.dev_rvalid, bus.cpu_rdata, bus.dev_rdata);
        end
        n_checks++;
        if (dut.starve_cnt_reg !== 8'd0) begin
            n_fail++; $display("FAIL reset_starve: got %0d required 0", dut.starve_cnt_reg);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.dev_req = 1'b0; bus.dev_lock = 1'b0;
        reset_low = 1'b1;
        idle(2);
    endtask

    // Scenario 1: the CPU read returns one cycle after its grant.
    task automatic test_cpu_read();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'h00010;
        #1;
        n_checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dev_gnt !== 1'b0 || bus.mem_en !== 1'b1 ||
            bus.mem_addr !== 17'h00010 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL cpu_read_gnt: gnt=%b/%b en=%b we=%b addr=%h required 1/0 1 0 00010",
                               bus.cpu_gnt, bus.dev_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF || bus.dev_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL cpu_read_data: rv=%b rdata=%h dev_rv=%b required 1 deadbeef 0",
                               bus.cpu_rvalid, bus.cpu_rdata, bus.dev_rvalid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL cpu_read_end: rv=%b rdata=%h required 0 0", bus.cpu_rvalid, bus.cpu_rdata);
        end
        idle(1);
    endtask

    // Scenario 2: both requesters held. The grant pattern is C,C,C,C,D repeating.
    task automatic test_starvation();
        logic        exp_cpu_rv = 1'b0;
        logic        exp_dev_rv = 1'b0;
        logic [16:0] exp_addr   = '0;
        for (int i = 0; i < 10; i++) begin
            logic exp_dev;
            exp_dev = (i % 5) == 4;
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'(32'h40 + i);
            bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 17'h20; bus.dev_lock = 1'b0;
            #1;
            n_checks++;
            if (bus.cpu_gnt !== !exp_dev || bus.dev_gnt !== exp_dev) begin
                n_fail++; $display("FAIL starve_pattern[%0d]: cpu_gnt=%b dev_gnt=%b required %b %b",
                                   i, bus.cpu_gnt, bus.dev_gnt, !exp_dev, exp_dev);
            end
            if (exp_dev) begin
                n_checks++;
                if (dut.starve_cnt_reg !== 8'd4) begin
                    n_fail++; $display("FAIL starve_cnt[%0d]: got %0d required 4", i, dut.starve_cnt_reg);
                end
            end
            n_checks++;
            if (bus.cpu_rvalid !== exp_cpu_rv || bus.dev_rvalid !== exp_dev_rv ||
                (exp_cpu_rv && bus.cpu_rdata !== pat(exp_addr)) ||
                (exp_dev_rv && bus.dev_rdata !== pat(exp_addr))) begin
                n_fail++; $display("FAIL starve_ret[%0d]: cpu_rv=%b dev_rv=%b cpu_rd=%h dev_rd=%h required %b %b data %h",
                                   i, bus.cpu_rvalid, bus.dev_rvalid, bus.cpu_rdata, bus.dev_rdata,
                                   exp_cpu_rv, exp_dev_rv, pat(exp_addr));
            end
            exp_cpu_rv = !exp_dev;
            exp_dev_rv = exp_dev;
            exp_addr   = exp_dev ? 17'h20 : 17'(32'h40 + i);
        end
        idle(2);
    endtask

    // Scenario 3: a locked device burst with the CPU held high. The device
    // gets 8 grants, then the RELEASE slot goes to the CPU, then 3 more CPU
    // grants follow, and then a forced device grant.
    task automatic test_lock_burst();
        int          dev_done   = 0;
        logic        exp_dev_rv = 1'b0;
        logic [16:0] exp_addr   = '0;
        for (int i = 0; i < 13; i++) begin
            logic exp_dev;
            exp_dev = (i < 8) || (i == 12);
            @(negedge clk);
            bus.cpu_req = (i != 0); bus.cpu_we = 1'b0; bus.cpu_addr = 17'h55;
            bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_lock = 1'b1;
            bus.dev_addr = 17'(32'h100 + dev_done);
            #1;
            n_checks++;
            if (bus.dev_gnt !== exp_dev || bus.cpu_gnt !== (!exp_dev && i != 0)) begin
                n_fail++; $display("FAIL lock_pattern[%0d]: cpu_gnt=%b dev_gnt=%b required %b %b",
                                   i, bus.cpu_gnt, bus.dev_gnt, !exp_dev && i != 0, exp_dev);
            end
            if (i == 12) begin
                n_checks++;
                if (dut.starve_cnt_reg !== 8'd4) begin
                    n_fail++; $display("FAIL lock_starve: got %0d required 4", dut.starve_cnt_reg);
                end
            end
            n_checks++;
            if (bus.dev_rvalid !== exp_dev_rv || (exp_dev_rv && bus.dev_rdata !== pat(exp_addr))) begin
                n_fail++; $display("FAIL lock_ret[%0d]: dev_rv=%b dev_rd=%h required %b %h",
                                   i, bus.dev_rvalid, bus.dev_rdata, exp_dev_rv, pat(exp_addr));
            end
            exp_dev_rv = exp_dev;
            exp_addr   = 17'(32'h100 + dev_done);
            if (exp_dev) dev_done++;
        end
        idle(2);
    endtask

    // Scenario 4: the device drops dev_lock after 3 grants, and the waiting
    // CPU wins the next cycle.
    task automatic test_lock_drop();
        for (int i = 0; i < 5; i++) begin
            logic exp_dev;
            exp_dev = (i < 3);
            @(negedge clk);
            bus.cpu_req = (i != 0); bus.cpu_we = 1'b0; bus.cpu_addr = 17'h77;
            bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 17'h200;
            bus.dev_lock = (i != 3);
            #1;
            n_checks++;
            if (bus.dev_gnt !== exp_dev || bus.cpu_gnt !== (!exp_dev)) begin
                n_fail++; $display("FAIL lock_drop[%0d]: cpu_gnt=%b dev_gnt=%b required %b %b",
                                   i, bus.cpu_gnt, bus.dev_gnt, !exp_dev, exp_dev);
            end
        end
        idle(2);
    endtask

    // Scenario 5: CPU write to the top address, then a device read of it.
    // Also checks the idle mux values.
    task automatic test_write_read();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'h1FFFF; bus.cpu_wdata = 32'h12345678;
        #1;
        n_checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h1FFFF ||
            bus.mem_wdata !== 32'h12345678) begin
            n_fail++; $display("FAIL write_mux: gnt=%b we=%b addr=%h wdata=%h required 1 1 1ffff 12345678",
                               bus.cpu_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 17'h1FFFF; bus.dev_lock = 1'b0;
        #1;
        n_checks++;
        if (bus.dev_gnt !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.dev_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL write_norv: dev_gnt=%b cpu_rv=%b dev_rv=%b required 1 0 0",
                               bus.dev_gnt, bus.cpu_rvalid, bus.dev_rvalid);
        end
        @(negedge clk);
        bus.dev_req = 1'b0;
        #1;
        n_checks++;
        if (bus.dev_rvalid !== 1'b1 || bus.dev_rdata !== 32'h12345678 || bus.cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL dev_readback: dev_rv=%b dev_rd=%h cpu_rv=%b required 1 12345678 0",
                               bus.dev_rvalid, bus.dev_rdata, bus.cpu_rvalid);
        end
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            n_fail++; $display("FAIL idle_mux: en=%b we=%b addr=%h wdata=%h required all 0",
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        idle(1);
    endtask

    // Scenario 6: reset arrives while a device read is in flight, so its
    // response is dropped.
    task automatic test_reset_inflight();
        @(negedge clk);
        bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 17'h33; bus.dev_lock = 1'b0;
        #1;
        n_checks++;
        if (bus.dev_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_flight_gnt: dev_gnt=%b required 1", bus.dev_gnt);
        end
        @(posedge clk);
        #1;
        reset_low = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 17'h44; bus.cpu_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.dev_rvalid !== 1'b0 || bus.dev_rdata !== '0 || bus.dev_gnt !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
                n_fail++; $display("FAIL rst_flight_hold[%0d]: dev_rv=%b dev_rd=%h gnt=%b/%b required 0 0 0/0",
                                   i, bus.dev_rvalid, bus.dev_rdata, bus.cpu_gnt, bus.dev_gnt);
            end
        end
        @(negedge clk);
        reset_low = 1'b1;
        #1;
        n_checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dev_gnt !== 1'b0 || bus.dev_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_first_gnt: cpu_gnt=%b dev_gnt=%b dev_rv=%b required 1 0 0",
                               bus.cpu_gnt, bus.dev_gnt, bus.dev_rvalid);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.dev_req = 1'b0;
        #1;
        n_checks++;
        if (bus.dev_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== pat(17'h44)) begin
            n_fail++; $display("FAIL rst_after: dev_rv=%b cpu_rv=%b cpu_rd=%h required 0 1 %h",
                               bus.dev_rvalid, bus.cpu_rvalid, bus.cpu_rdata, pat(17'h44));
        end
        idle(2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < (1 << 17); i++) ram[i] = pat(17'(i));
        ram[17'h10] = 32'hDEADBEEF;
        test_reset();
        test_cpu_read();
        test_starvation();
        test_lock_burst();
        test_lock_drop();
        test_write_read();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
